// File: rtl/stack_pkg.sv
// Shared definitions for the data-stack engine: opcodes, error flag
// positions and the control FSM state type.
package stack_pkg;

    localparam logic [2:0] OP_NOP     = 3'b000;
    localparam logic [2:0] OP_PUSH    = 3'b001;
    localparam logic [2:0] OP_POP     = 3'b010;
    localparam logic [2:0] OP_REPLACE = 3'b011;
    localparam logic [2:0] OP_DUP     = 3'b100;
    localparam logic [2:0] OP_SWAP    = 3'b101;
    localparam logic [2:0] OP_PICK    = 3'b110;
    localparam logic [2:0] OP_CLEAR   = 3'b111;

    localparam int ERR_OVF = 0;
    localparam int ERR_UNF = 1;

    typedef enum logic {
        IDLE    = 1'b0,
        PICK_WR = 1'b1
    } state_t;

endpackage

// File: rtl/stack_regfile.sv
// Register-file storage for the stack: two synchronous write ports (the
// second exists only so SWAP can exchange two entries in one edge) and
// three combinational read ports for top, next and pick.
module stack_regfile #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             i_clock,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_we2,
    input  logic [IDX_W-1:0] i_waddr2,
    input  logic [WIDTH-1:0] i_wdata2,
    input  logic [IDX_W-1:0] i_top_addr,
    input  logic [IDX_W-1:0] i_next_addr,
    input  logic [IDX_W-1:0] i_pick_addr,
    output logic [WIDTH-1:0] o_top_data,
    output logic [WIDTH-1:0] o_next_data,
    output logic [WIDTH-1:0] o_pick_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Storage writes; the two ports never target the same entry, so their order is irrelevant
    always_ff @(posedge i_clock) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_we2) begin
            r_mem[i_waddr2] <= i_wdata2;
        end
    end

    assign o_top_data  = r_mem[i_top_addr];
    assign o_next_data = r_mem[i_next_addr];
    assign o_pick_data = r_mem[i_pick_addr];

endmodule

// File: rtl/stack_unit.sv
// Parametrised data-stack engine: holds the depth counter, sticky error
// flags, the PICK FSM and its buffer, and drives the register file.
import stack_pkg::*;

module stack_unit #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_data,
    input  logic [IDX_W-1:0] i_idx,
    output logic [WIDTH-1:0] o_top,
    output logic [WIDTH-1:0] o_next,
    output logic [IDX_W:0]   o_depth,
    output logic             o_empty,
    output logic             o_full,
    output logic [1:0]       o_err
);

    localparam logic [IDX_W-1:0] ONE_IDX    = IDX_W'(1);
    localparam logic [IDX_W-1:0] TWO_IDX    = IDX_W'(2);
    localparam logic [IDX_W:0]   DEPTH_ONE  = (IDX_W+1)'(1);
    localparam logic [IDX_W:0]   DEPTH_TWO  = (IDX_W+1)'(2);
    localparam logic [IDX_W:0]   DEPTH_FULL = (IDX_W+1)'(DEPTH);

    state_t           r_state;
    logic [IDX_W:0]   r_depth;
    logic [1:0]       r_err;
    logic [WIDTH-1:0] r_pick_buf;

    state_t           w_state_nxt;
    logic [IDX_W:0]   w_depth_nxt;
    logic [1:0]       w_err_nxt;
    logic             w_pick_load;

    logic             w_we;
    logic [IDX_W-1:0] w_waddr;
    logic [WIDTH-1:0] w_wdata;
    logic             w_we2;
    logic [IDX_W-1:0] w_waddr2;
    logic [WIDTH-1:0] w_wdata2;

    logic [IDX_W-1:0] w_depth_lo;
    logic [IDX_W-1:0] w_top_addr;
    logic [IDX_W-1:0] w_next_addr;
    logic [IDX_W-1:0] w_pick_addr;
    logic [WIDTH-1:0] w_top_raw;
    logic [WIDTH-1:0] w_next_raw;
    logic [WIDTH-1:0] w_pick_raw;

    logic             w_empty;
    logic             w_full;
    logic             w_lt2;
    logic             w_pick_range_err;

    // The low depth bits address the next free slot; when full they wrap to 0,
    // which still makes depth_lo-1 the correct top address.
    assign w_depth_lo       = r_depth[IDX_W-1:0];
    assign w_top_addr       = w_depth_lo - ONE_IDX;
    assign w_next_addr      = w_depth_lo - TWO_IDX;
    assign w_pick_addr      = w_top_addr - i_idx;

    assign w_empty          = (r_depth == '0);
    assign w_full           = (r_depth == DEPTH_FULL);
    assign w_lt2            = (r_depth < DEPTH_TWO);
    assign w_pick_range_err = ({1'b0, i_idx} >= r_depth);

    stack_regfile #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_regfile (
        .i_clock     (i_clock),
        .i_we        (w_we),
        .i_waddr     (w_waddr),
        .i_wdata     (w_wdata),
        .i_we2       (w_we2),
        .i_waddr2    (w_waddr2),
        .i_wdata2    (w_wdata2),
        .i_top_addr  (w_top_addr),
        .i_next_addr (w_next_addr),
        .i_pick_addr (w_pick_addr),
        .o_top_data  (w_top_raw),
        .o_next_data (w_next_raw),
        .o_pick_data (w_pick_raw)
    );

    // Operation decode: next state, depth, error flags and register-file writes
    always_comb begin
        w_state_nxt = r_state;
        w_depth_nxt = r_depth;
        w_err_nxt   = r_err;
        w_pick_load = 1'b0;
        w_we        = 1'b0;
        w_waddr     = w_depth_lo;
        w_wdata     = i_data;
        w_we2       = 1'b0;
        w_waddr2    = w_next_addr;
        w_wdata2    = w_top_raw;
        o_ready     = 1'b0;

        case (r_state)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    case (i_op)
                        OP_PUSH: begin
                            if (w_full) begin
                                w_err_nxt[ERR_OVF] = 1'b1;
                            end else begin
                                w_we        = 1'b1;
                                w_waddr     = w_depth_lo;
                                w_wdata     = i_data;
                                w_depth_nxt = r_depth + DEPTH_ONE;
                            end
                        end
                        OP_POP: begin
                            if (w_empty) begin
                                w_err_nxt[ERR_UNF] = 1'b1;
                            end else begin
                                w_depth_nxt = r_depth - DEPTH_ONE;
                            end
                        end
                        OP_REPLACE: begin
                            if (w_empty) begin
                                w_err_nxt[ERR_UNF] = 1'b1;
                            end else begin
                                w_we    = 1'b1;
                                w_waddr = w_top_addr;
                                w_wdata = i_data;
                            end
                        end
                        OP_DUP: begin
                            if (w_full) begin
                                w_err_nxt[ERR_OVF] = 1'b1;
                            end else if (w_empty) begin
                                w_err_nxt[ERR_UNF] = 1'b1;
                            end else begin
                                w_we        = 1'b1;
                                w_waddr     = w_depth_lo;
                                w_wdata     = w_top_raw;
                                w_depth_nxt = r_depth + DEPTH_ONE;
                            end
                        end
                        OP_SWAP: begin
                            if (w_lt2) begin
                                w_err_nxt[ERR_UNF] = 1'b1;
                            end else begin
                                w_we     = 1'b1;
                                w_waddr  = w_top_addr;
                                w_wdata  = w_next_raw;
                                w_we2    = 1'b1;
                                w_waddr2 = w_next_addr;
                                w_wdata2 = w_top_raw;
                            end
                        end
                        OP_PICK: begin
                            if (w_full) begin
                                w_err_nxt[ERR_OVF] = 1'b1;
                            end
                            if (w_pick_range_err) begin
                                w_err_nxt[ERR_UNF] = 1'b1;
                            end
                            if (!w_full && !w_pick_range_err) begin
                                w_pick_load = 1'b1;
                                w_state_nxt = PICK_WR;
                            end
                        end
                        OP_CLEAR: begin
                            w_depth_nxt = '0;
                            w_err_nxt   = 2'b00;
                        end
                        default: begin
                        end
                    endcase
                end
            end
            PICK_WR: begin
                w_we        = 1'b1;
                w_waddr     = w_depth_lo;
                w_wdata     = r_pick_buf;
                w_depth_nxt = r_depth + DEPTH_ONE;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Control state registers; reset abandons any pick in progress
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= IDLE;
            r_depth    <= '0;
            r_err      <= 2'b00;
            r_pick_buf <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_depth <= w_depth_nxt;
            r_err   <= w_err_nxt;
            if (w_pick_load) begin
                r_pick_buf <= w_pick_raw;
            end
        end
    end

    assign o_top   = w_empty ? '0 : w_top_raw;
    assign o_next  = w_lt2   ? '0 : w_next_raw;
    assign o_depth = r_depth;
    assign o_empty = w_empty;
    assign o_full  = w_full;
    assign o_err   = r_err;

endmodule

// File: tb/tb_stack_unit.sv
// Scoreboard bench for stack_unit: a driver issues directed operations and
// queues the hand-computed stack view expected after each one; a monitor
// compares the queued view against the DUT on the cycle it becomes due.
module tb_stack_unit;
    import stack_pkg::*;

    localparam int WIDTH = 16;
    localparam int DEPTH = 16;
    localparam int IDX_W = 4;

    logic             i_clock   = 1'b0;
    logic             i_reset_n = 1'b0;
    logic             i_valid   = 1'b0;
    logic [2:0]       i_op      = OP_NOP;
    logic [WIDTH-1:0] i_data    = '0;
    logic [IDX_W-1:0] i_idx     = '0;
    logic             o_ready;
    logic [WIDTH-1:0] o_top;
    logic [WIDTH-1:0] o_next;
    logic [IDX_W:0]   o_depth;
    logic             o_empty;
    logic             o_full;
    logic [1:0]       o_err;

    typedef struct {
        int               id;
        int               due;
        logic             readyOnly;
        logic             readyExp;
        logic [WIDTH-1:0] top;
        logic [WIDTH-1:0] next;
        logic [IDX_W:0]   depth;
        logic [1:0]       err;
    } exp_t;

    exp_t sbQueue[$];
    exp_t monExp;
    int   checkCount = 0;
    int   errorCount = 0;
    int   cycleCount = 0;
    int   vecId      = 0;

    stack_unit #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_op      (i_op),
        .i_data    (i_data),
        .i_idx     (i_idx),
        .o_top     (o_top),
        .o_next    (o_next),
        .o_depth   (o_depth),
        .o_empty   (o_empty),
        .o_full    (o_full),
        .o_err     (o_err)
    );

    // Free-running clock, 10 time units per period
    always #5 i_clock = ~i_clock;

    // Count rising edges so queued expectations can name the cycle they belong to
    always @(posedge i_clock) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s vec%0d: got %0h expected %0h", name, id, act, exp);
        end
    endtask

    // Drive one operation, wait for acceptance, and queue what the stack must look like afterwards
    task automatic applyStimulus(input logic [2:0] op, input logic [WIDTH-1:0] data, input logic [IDX_W-1:0] idx,
                                 input logic [WIDTH-1:0] eTop, input logic [WIDTH-1:0] eNext,
                                 input logic [IDX_W:0] eDepth, input logic [1:0] eErr, input logic twoCycle);
        exp_t e;
        exp_t mid;
        int   budget;
        budget  = 0;
        i_valid = 1'b1;
        i_op    = op;
        i_data  = data;
        i_idx   = idx;
        while (!o_ready && budget < 8) begin
            @(negedge i_clock);
            budget++;
        end
        if (!o_ready) begin
            checkCount++;
            errorCount++;
            $display("[TB] FAIL handshake vec%0d: o_ready %b expected 1", vecId, o_ready);
            i_valid = 1'b0;
            vecId++;
            return;
        end
        e.id        = vecId;
        e.readyOnly = 1'b0;
        e.readyExp  = 1'b1;
        e.top       = eTop;
        e.next      = eNext;
        e.depth     = eDepth;
        e.err       = eErr;
        if (twoCycle) begin
            mid           = e;
            mid.readyOnly = 1'b1;
            mid.readyExp  = 1'b0;
            mid.due       = cycleCount + 1;
            sbQueue.push_back(mid);
            e.due = cycleCount + 2;
        end else begin
            e.due = cycleCount + 1;
        end
        sbQueue.push_back(e);
        @(negedge i_clock);
        i_valid = 1'b0;
        i_op    = OP_NOP;
        vecId++;
    endtask

    task automatic waitDrain();
        int budget;
        budget = 0;
        while (sbQueue.size() > 0 && budget < 20) begin
            @(negedge i_clock);
            budget++;
        end
        if (sbQueue.size() > 0) begin
            checkCount++;
            errorCount++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", sbQueue.size());
            sbQueue.delete();
        end
    endtask

    // Monitor: on each falling edge compare the DUT against the expectation that is due now
    always @(negedge i_clock) begin
        if (sbQueue.size() > 0) begin
            if (sbQueue[0].due < cycleCount) begin
                checkCount++;
                errorCount++;
                $display("[TB] FAIL stale vec%0d: due %0d now %0d", sbQueue[0].id, sbQueue[0].due, cycleCount);
                void'(sbQueue.pop_front());
            end else if (sbQueue[0].due == cycleCount) begin
                monExp = sbQueue.pop_front();
                checkOutput("ready", monExp.id, 32'(o_ready), 32'(monExp.readyExp));
                if (!monExp.readyOnly) begin
                    checkOutput("top",   monExp.id, 32'(o_top),   32'(monExp.top));
                    checkOutput("next",  monExp.id, 32'(o_next),  32'(monExp.next));
                    checkOutput("depth", monExp.id, 32'(o_depth), 32'(monExp.depth));
                    checkOutput("err",   monExp.id, 32'(o_err),   32'(monExp.err));
                    checkOutput("empty", monExp.id, 32'(o_empty), 32'(monExp.depth == 0));
                    checkOutput("full",  monExp.id, 32'(o_full),  32'(monExp.depth == DEPTH));
                end
            end
        end
    end

    // Watchdog so the run always ends even if the stimulus stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Directed stimulus sequence
    initial begin
        i_reset_n = 1'b0;
        repeat (3) @(negedge i_clock);
        checkOutput("rst_depth", -1, 32'(o_depth), 32'd0);
        checkOutput("rst_ready", -1, 32'(o_ready), 32'd1);
        checkOutput("rst_err",   -1, 32'(o_err),   32'd0);
        checkOutput("rst_top",   -1, 32'(o_top),   32'd0);
        checkOutput("rst_empty", -1, 32'(o_empty), 32'd1);
        i_reset_n = 1'b1;
        @(negedge i_clock);

        // Two pushes
        applyStimulus(OP_PUSH, 16'h1234, 4'd0, 16'h1234, 16'h0000, 5'd1, 2'b00, 1'b0);
        applyStimulus(OP_PUSH, 16'hABCD, 4'd0, 16'hABCD, 16'h1234, 5'd2, 2'b00, 1'b0);
        applyStimulus(OP_CLEAR, 16'h0,   4'd0, 16'h0000, 16'h0000, 5'd0, 2'b00, 1'b0);

        // Fill to full, then overflow with PUSH, DUP and PICK
        for (int i = 0; i < 16; i++) begin
            applyStimulus(OP_PUSH, 16'(i), 4'd0, 16'(i), (i == 0) ? 16'h0000 : 16'(i - 1), 5'(i + 1), 2'b00, 1'b0);
        end
        applyStimulus(OP_PUSH, 16'h0099, 4'd0, 16'h000F, 16'h000E, 5'd16, 2'b01, 1'b0);
        applyStimulus(OP_DUP,  16'h0,    4'd0, 16'h000F, 16'h000E, 5'd16, 2'b01, 1'b0);
        applyStimulus(OP_PICK, 16'h0,    4'd0, 16'h000F, 16'h000E, 5'd16, 2'b01, 1'b0);
        applyStimulus(OP_CLEAR, 16'h0,   4'd0, 16'h0000, 16'h0000, 5'd0,  2'b00, 1'b0);

        // Underflow cases on an empty or shallow stack
        applyStimulus(OP_DUP,  16'h0,    4'd0, 16'h0000, 16'h0000, 5'd0, 2'b10, 1'b0);
        applyStimulus(OP_POP,  16'h0,    4'd0, 16'h0000, 16'h0000, 5'd0, 2'b10, 1'b0);
        applyStimulus(OP_PUSH, 16'h0007, 4'd0, 16'h0007, 16'h0000, 5'd1, 2'b10, 1'b0);
        applyStimulus(OP_SWAP, 16'h0,    4'd0, 16'h0007, 16'h0000, 5'd1, 2'b10, 1'b0);
        applyStimulus(OP_CLEAR, 16'h0,   4'd0, 16'h0000, 16'h0000, 5'd0, 2'b00, 1'b0);
        applyStimulus(OP_REPLACE, 16'h0055, 4'd0, 16'h0000, 16'h0000, 5'd0, 2'b10, 1'b0);
        applyStimulus(OP_CLEAR, 16'h0,   4'd0, 16'h0000, 16'h0000, 5'd0, 2'b00, 1'b0);

        // PICK: legal two-cycle copy, then out of range
        applyStimulus(OP_PUSH, 16'h0001, 4'd0, 16'h0001, 16'h0000, 5'd1, 2'b00, 1'b0);
        applyStimulus(OP_PUSH, 16'h0002, 4'd0, 16'h0002, 16'h0001, 5'd2, 2'b00, 1'b0);
        applyStimulus(OP_PUSH, 16'h0003, 4'd0, 16'h0003, 16'h0002, 5'd3, 2'b00, 1'b0);
        applyStimulus(OP_PICK, 16'h0,    4'd2, 16'h0001, 16'h0003, 5'd4, 2'b00, 1'b1);
        applyStimulus(OP_PICK, 16'h0,    4'd4, 16'h0001, 16'h0003, 5'd4, 2'b10, 1'b0);
        applyStimulus(OP_CLEAR, 16'h0,   4'd0, 16'h0000, 16'h0000, 5'd0, 2'b00, 1'b0);

        // SWAP, DUP, REPLACE, POP, NOP, PICK idx=1
        applyStimulus(OP_PUSH,    16'h0005, 4'd0, 16'h0005, 16'h0000, 5'd1, 2'b00, 1'b0);
        applyStimulus(OP_PUSH,    16'h0009, 4'd0, 16'h0009, 16'h0005, 5'd2, 2'b00, 1'b0);
        applyStimulus(OP_SWAP,    16'h0,    4'd0, 16'h0005, 16'h0009, 5'd2, 2'b00, 1'b0);
        applyStimulus(OP_DUP,     16'h0,    4'd0, 16'h0005, 16'h0005, 5'd3, 2'b00, 1'b0);
        applyStimulus(OP_REPLACE, 16'h00FF, 4'd0, 16'h00FF, 16'h0005, 5'd3, 2'b00, 1'b0);
        applyStimulus(OP_POP,     16'h0,    4'd0, 16'h0005, 16'h0009, 5'd2, 2'b00, 1'b0);
        applyStimulus(OP_NOP,     16'h0,    4'd0, 16'h0005, 16'h0009, 5'd2, 2'b00, 1'b0);
        applyStimulus(OP_PICK,    16'h0,    4'd1, 16'h0009, 16'h0005, 5'd3, 2'b00, 1'b1);
        applyStimulus(OP_CLEAR,   16'h0,    4'd0, 16'h0000, 16'h0000, 5'd0, 2'b00, 1'b0);

        // Reset asserted while the pick write is pending
        applyStimulus(OP_PUSH, 16'h0042, 4'd0, 16'h0042, 16'h0000, 5'd1, 2'b00, 1'b0);
        waitDrain();
        i_valid = 1'b1;
        i_op    = OP_PICK;
        i_idx   = 4'd0;
        @(negedge i_clock);
        i_valid = 1'b0;
        i_op    = OP_NOP;
        checkOutput("pick_busy", -2, 32'(o_ready), 32'd0);
        i_reset_n = 1'b0;
        #1;
        checkOutput("abort_depth", -2, 32'(o_depth), 32'd0);
        checkOutput("abort_ready", -2, 32'(o_ready), 32'd1);
        checkOutput("abort_top",   -2, 32'(o_top),   32'd0);
        @(negedge i_clock);
        i_reset_n = 1'b1;
        repeat (2) @(negedge i_clock);
        checkOutput("post_depth", -3, 32'(o_depth), 32'd0);
        checkOutput("post_top",   -3, 32'(o_top),   32'd0);
        checkOutput("post_err",   -3, 32'(o_err),   32'd0);
        checkOutput("post_ready", -3, 32'(o_ready), 32'd1);
        applyStimulus(OP_PUSH, 16'h0077, 4'd0, 16'h0077, 16'h0000, 5'd1, 2'b00, 1'b0);
        waitDrain();

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
